// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: ALU operation classes, opcodes and the
// packed control-bundle layout carried from ID to EX.
package mips_pkg;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_OR    = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_RTYPE = 3'b100;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  localparam int CTRL_W          = 10;
  localparam int CTRL_REG_DST    = 0;
  localparam int CTRL_REG_WRITE  = 1;
  localparam int CTRL_ALU_SRC    = 2;
  localparam int CTRL_ALU_OP_LSB = 3;
  localparam int CTRL_MEM_WRITE  = 6;
  localparam int CTRL_MEM_READ   = 7;
  localparam int CTRL_MEM_TO_REG = 8;
  localparam int CTRL_PC_SRC     = 9;

  // Reference decode of an opcode into the control bundle; unknown opcodes give a NOP bundle.
  function automatic logic [CTRL_W-1:0] decode_ctrl(input logic [5:0] op);
    logic [CTRL_W-1:0] c;
    c = '0;
    case (op)
      OP_RTYPE: begin
        c[CTRL_REG_DST]                = 1'b1;
        c[CTRL_REG_WRITE]              = 1'b1;
        c[CTRL_ALU_OP_LSB +: 3]        = ALU_RTYPE;
      end
      OP_ADDI: begin
        c[CTRL_REG_WRITE]              = 1'b1;
        c[CTRL_ALU_SRC]                = 1'b1;
        c[CTRL_ALU_OP_LSB +: 3]        = ALU_ADD;
      end
      OP_LW, OP_LH, OP_LHU: begin
        c[CTRL_REG_WRITE]              = 1'b1;
        c[CTRL_ALU_SRC]                = 1'b1;
        c[CTRL_MEM_READ]               = 1'b1;
        c[CTRL_MEM_TO_REG]             = 1'b1;
        c[CTRL_ALU_OP_LSB +: 3]        = ALU_ADD;
      end
      OP_SW: begin
        c[CTRL_ALU_SRC]                = 1'b1;
        c[CTRL_MEM_WRITE]              = 1'b1;
        c[CTRL_ALU_OP_LSB +: 3]        = ALU_ADD;
      end
      OP_BEQ: begin
        c[CTRL_PC_SRC]                 = 1'b1;
        c[CTRL_ALU_OP_LSB +: 3]        = ALU_SUB;
      end
      OP_ANDI: begin
        c[CTRL_REG_WRITE]              = 1'b1;
        c[CTRL_ALU_SRC]                = 1'b1;
        c[CTRL_ALU_OP_LSB +: 3]        = ALU_AND;
      end
      OP_ORI: begin
        c[CTRL_REG_WRITE]              = 1'b1;
        c[CTRL_ALU_SRC]                = 1'b1;
        c[CTRL_ALU_OP_LSB +: 3]        = ALU_OR;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_ex_pipeline_reg_if.sv
// ID/EX boundary bundle: decode-side inputs, EX-side registered copies,
// fetch write enables and performance counters.
interface id_ex_pipeline_reg_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic                  id_valid;
  logic                  id_reg_dst, id_reg_write, id_alu_src;
  logic                  id_mem_write, id_mem_read, id_mem_to_reg, id_pc_src;
  logic [2:0]            id_alu_op;
  logic [DATA_W-1:0]     id_rs_data, id_rt_data, id_imm, id_pc_plus4;
  logic [REG_ADDR_W-1:0] id_rs, id_rt, id_rd;
  logic                  ext_stall;
  logic                  flush;

  logic                  ex_valid;
  logic                  ex_reg_dst, ex_reg_write, ex_alu_src;
  logic                  ex_mem_write, ex_mem_read, ex_mem_to_reg, ex_pc_src;
  logic [2:0]            ex_alu_op;
  logic [DATA_W-1:0]     ex_rs_data, ex_rt_data, ex_imm, ex_pc_plus4;
  logic [REG_ADDR_W-1:0] ex_rs, ex_rt, ex_rd;
  logic                  pc_write_en, if_id_write_en;
  logic [CNT_W-1:0]      bubble_count, flush_count;

  modport master (
    output id_valid, id_reg_dst, id_reg_write, id_alu_src, id_mem_write, id_mem_read,
           id_mem_to_reg, id_pc_src, id_alu_op, id_rs_data, id_rt_data, id_imm,
           id_pc_plus4, id_rs, id_rt, id_rd, ext_stall, flush,
    input  ex_valid, ex_reg_dst, ex_reg_write, ex_alu_src, ex_mem_write, ex_mem_read,
           ex_mem_to_reg, ex_pc_src, ex_alu_op, ex_rs_data, ex_rt_data, ex_imm,
           ex_pc_plus4, ex_rs, ex_rt, ex_rd, pc_write_en, if_id_write_en,
           bubble_count, flush_count
  );

  modport slave (
    input  id_valid, id_reg_dst, id_reg_write, id_alu_src, id_mem_write, id_mem_read,
           id_mem_to_reg, id_pc_src, id_alu_op, id_rs_data, id_rt_data, id_imm,
           id_pc_plus4, id_rs, id_rt, id_rd, ext_stall, flush,
    output ex_valid, ex_reg_dst, ex_reg_write, ex_alu_src, ex_mem_write, ex_mem_read,
           ex_mem_to_reg, ex_pc_src, ex_alu_op, ex_rs_data, ex_rt_data, ex_imm,
           ex_pc_plus4, ex_rs, ex_rt, ex_rd, pc_write_en, if_id_write_en,
           bubble_count, flush_count
  );
endinterface

// File: rtl/id_ex_pipeline_reg_load_use_detector.sv
// Combinational load-use check: a load in EX whose destination is read by the
// instruction in ID. $zero never counts as a dependency.
module load_use_detector #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_alu_src,
  input  logic                  id_mem_write,
  output logic                  load_use
);
  logic rs_hit;
  logic rt_hit;

  assign rs_hit = (ex_rt == id_rs);
  // id_rt is only a source when it feeds the ALU or supplies store data.
  assign rt_hit = (ex_rt == id_rt) & (~id_alu_src | id_mem_write);

  assign load_use = ex_valid & ex_mem_read & (ex_rt != '0) & (rs_hit | rt_hit) & id_valid;
endmodule

// File: rtl/id_ex_pipeline_reg.sv
// ID->EX pipeline register with load-use bubble insertion, flush, fetch
// write-enable generation and saturating bubble/flush counters.
module id_ex_pipeline_reg
  import mips_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input logic              clk,
  input logic              rst_n,
  id_ex_pipeline_reg_if.slave bus
);
  logic                  load_use, hazard_stall;
  logic [CTRL_W-1:0]     id_ctrl;

  logic                  valid_q, valid_d;
  logic [CTRL_W-1:0]     ctrl_q, ctrl_d;
  logic [DATA_W-1:0]     rs_data_q, rs_data_d, rt_data_q, rt_data_d;
  logic [DATA_W-1:0]     imm_q, imm_d, pc_plus4_q, pc_plus4_d;
  logic [REG_ADDR_W-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [CNT_W-1:0]      bubble_cnt_q, bubble_cnt_d, flush_cnt_q, flush_cnt_d;

  load_use_detector #(.REG_ADDR_W(REG_ADDR_W)) u_load_use (
    .ex_valid     (valid_q),
    .ex_mem_read  (ctrl_q[CTRL_MEM_READ]),
    .ex_rt        (rt_q),
    .id_valid     (bus.id_valid),
    .id_rs        (bus.id_rs),
    .id_rt        (bus.id_rt),
    .id_alu_src   (bus.id_alu_src),
    .id_mem_write (bus.id_mem_write),
    .load_use     (load_use)
  );

  assign hazard_stall = load_use & ~bus.flush;

  // Fetch is released while in reset so the front end can restart cleanly.
  assign bus.pc_write_en    = ~rst_n | (~hazard_stall & ~bus.ext_stall);
  assign bus.if_id_write_en = ~rst_n | (~hazard_stall & ~bus.ext_stall);

  always_comb begin
    id_ctrl                           = '0;
    id_ctrl[CTRL_REG_DST]             = bus.id_reg_dst;
    id_ctrl[CTRL_REG_WRITE]           = bus.id_reg_write;
    id_ctrl[CTRL_ALU_SRC]             = bus.id_alu_src;
    id_ctrl[CTRL_ALU_OP_LSB +: 3]     = bus.id_alu_op;
    id_ctrl[CTRL_MEM_WRITE]           = bus.id_mem_write;
    id_ctrl[CTRL_MEM_READ]            = bus.id_mem_read;
    id_ctrl[CTRL_MEM_TO_REG]          = bus.id_mem_to_reg;
    id_ctrl[CTRL_PC_SRC]              = bus.id_pc_src;
  end

  always_comb begin
    valid_d      = valid_q;
    ctrl_d       = ctrl_q;
    rs_data_d    = rs_data_q;
    rt_data_d    = rt_data_q;
    imm_d        = imm_q;
    pc_plus4_d   = pc_plus4_q;
    rs_d         = rs_q;
    rt_d         = rt_q;
    rd_d         = rd_q;
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;

    if (bus.flush) begin
      valid_d     = 1'b0;
      ctrl_d      = '0;
      rs_data_d   = '0;
      rt_data_d   = '0;
      imm_d       = '0;
      pc_plus4_d  = '0;
      rs_d        = '0;
      rt_d        = '0;
      rd_d        = '0;
      flush_cnt_d = (flush_cnt_q == '1) ? flush_cnt_q : flush_cnt_q + CNT_W'(1);
    end else if (bus.ext_stall) begin
      // freeze: defaults already hold every register
    end else if (hazard_stall) begin
      valid_d      = 1'b0;
      ctrl_d       = '0;
      bubble_cnt_d = (bubble_cnt_q == '1) ? bubble_cnt_q : bubble_cnt_q + CNT_W'(1);
    end else begin
      valid_d    = bus.id_valid;
      ctrl_d     = bus.id_valid ? id_ctrl : '0;
      rs_data_d  = bus.id_rs_data;
      rt_data_d  = bus.id_rt_data;
      imm_d      = bus.id_imm;
      pc_plus4_d = bus.id_pc_plus4;
      rs_d       = bus.id_rs;
      rt_d       = bus.id_rt;
      rd_d       = bus.id_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      ctrl_q       <= '0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      pc_plus4_q   <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      valid_q      <= valid_d;
      ctrl_q       <= ctrl_d;
      rs_data_q    <= rs_data_d;
      rt_data_q    <= rt_data_d;
      imm_q        <= imm_d;
      pc_plus4_q   <= pc_plus4_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      rd_q         <= rd_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bus.ex_valid      = valid_q;
  assign bus.ex_reg_dst    = ctrl_q[CTRL_REG_DST];
  assign bus.ex_reg_write  = ctrl_q[CTRL_REG_WRITE];
  assign bus.ex_alu_src    = ctrl_q[CTRL_ALU_SRC];
  assign bus.ex_alu_op     = ctrl_q[CTRL_ALU_OP_LSB +: 3];
  assign bus.ex_mem_write  = ctrl_q[CTRL_MEM_WRITE];
  assign bus.ex_mem_read   = ctrl_q[CTRL_MEM_READ];
  assign bus.ex_mem_to_reg = ctrl_q[CTRL_MEM_TO_REG];
  assign bus.ex_pc_src     = ctrl_q[CTRL_PC_SRC];
  assign bus.ex_rs_data    = rs_data_q;
  assign bus.ex_rt_data    = rt_data_q;
  assign bus.ex_imm        = imm_q;
  assign bus.ex_pc_plus4   = pc_plus4_q;
  assign bus.ex_rs         = rs_q;
  assign bus.ex_rt         = rt_q;
  assign bus.ex_rd         = rd_q;
  assign bus.bubble_count  = bubble_cnt_q;
  assign bus.flush_count   = flush_cnt_q;
endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Scoreboard bench for id_ex_pipeline_reg: a driver queues hand-computed
// expectations per vector, a monitor pops and compares each cycle.
module tb_id_ex_pipeline_reg;
  logic clk;
  logic rst_n;

  id_ex_pipeline_reg_if #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(16)) i1 ();
  id_ex_pipeline_reg_if #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(2))  i2 ();

  id_ex_pipeline_reg #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(i1));
  id_ex_pipeline_reg #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(2)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(i2));

  assign i2.id_valid      = i1.id_valid;
  assign i2.id_reg_dst    = i1.id_reg_dst;
  assign i2.id_reg_write  = i1.id_reg_write;
  assign i2.id_alu_src    = i1.id_alu_src;
  assign i2.id_mem_write  = i1.id_mem_write;
  assign i2.id_mem_read   = i1.id_mem_read;
  assign i2.id_mem_to_reg = i1.id_mem_to_reg;
  assign i2.id_pc_src     = i1.id_pc_src;
  assign i2.id_alu_op     = i1.id_alu_op;
  assign i2.id_rs_data    = i1.id_rs_data;
  assign i2.id_rt_data    = i1.id_rt_data;
  assign i2.id_imm        = i1.id_imm;
  assign i2.id_pc_plus4   = i1.id_pc_plus4;
  assign i2.id_rs         = i1.id_rs;
  assign i2.id_rt         = i1.id_rt;
  assign i2.id_rd         = i1.id_rd;
  assign i2.ext_stall     = i1.ext_stall;
  assign i2.flush         = i1.flush;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // control bits, MSB..LSB: pc_src mem_to_reg mem_read mem_write alu_op[2:0] alu_src reg_write reg_dst
  localparam logic [9:0] C_ADDI  = 10'h006;
  localparam logic [9:0] C_LW    = 10'h186;
  localparam logic [9:0] C_RTYPE = 10'h023;

  typedef struct {
    logic       vld;
    logic [9:0] ctrl;
    logic [31:0] rsd, rtd, imm, pc4;
    logic [4:0] rs, rt, rd;
    logic       es, fl;
  } stim_t;

  typedef struct {
    logic        pcwe;
    logic        vld;
    logic [9:0]  ctrl;
    logic [31:0] rsd, rtd, imm, pc4;
    logic [4:0]  rs, rt, rd;
    logic [15:0] bub, flc;
    logic [1:0]  sflc;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  function automatic stim_t mk(input logic vld, input logic [9:0] ctrl,
                               input logic [31:0] rsd, rtd, imm, pc4,
                               input logic [4:0] rs, rt, rd, input logic es, fl);
    stim_t s;
    s.vld = vld; s.ctrl = ctrl; s.rsd = rsd; s.rtd = rtd; s.imm = imm; s.pc4 = pc4;
    s.rs = rs; s.rt = rt; s.rd = rd; s.es = es; s.fl = fl;
    return s;
  endfunction

  // EX holding the fields of s (control zeroed when s carried no instruction)
  function automatic exp_t ld(input stim_t s, input logic pcwe, input int bub, flc, sflc);
    exp_t e;
    e.pcwe = pcwe; e.vld = s.vld; e.ctrl = s.vld ? s.ctrl : 10'h000;
    e.rsd = s.rsd; e.rtd = s.rtd; e.imm = s.imm; e.pc4 = s.pc4;
    e.rs = s.rs; e.rt = s.rt; e.rd = s.rd;
    e.bub = 16'(bub); e.flc = 16'(flc); e.sflc = 2'(sflc);
    return e;
  endfunction

  // bubble: data of s retained, control and valid cleared
  function automatic exp_t bb(input stim_t s, input logic pcwe, input int bub, flc, sflc);
    exp_t e;
    e = ld(s, pcwe, bub, flc, sflc);
    e.vld = 1'b0; e.ctrl = 10'h000;
    return e;
  endfunction

  function automatic exp_t zz(input logic pcwe, input int bub, flc, sflc);
    stim_t z;
    z = mk(1'b0, 10'h000, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    return ld(z, pcwe, bub, flc, sflc);
  endfunction

  task automatic apply(input stim_t s);
    i1.id_valid      = s.vld;
    i1.id_reg_dst    = s.ctrl[0];
    i1.id_reg_write  = s.ctrl[1];
    i1.id_alu_src    = s.ctrl[2];
    i1.id_alu_op     = s.ctrl[5:3];
    i1.id_mem_write  = s.ctrl[6];
    i1.id_mem_read   = s.ctrl[7];
    i1.id_mem_to_reg = s.ctrl[8];
    i1.id_pc_src     = s.ctrl[9];
    i1.id_rs_data    = s.rsd;
    i1.id_rt_data    = s.rtd;
    i1.id_imm        = s.imm;
    i1.id_pc_plus4   = s.pc4;
    i1.id_rs         = s.rs;
    i1.id_rt         = s.rt;
    i1.id_rd         = s.rd;
    i1.ext_stall     = s.es;
    i1.flush         = s.fl;
  endtask

  task automatic step(input stim_t s, input exp_t e);
    @(negedge clk);
    apply(s);
    sb.push_back(e);
  endtask

  function automatic logic [9:0] act_ctrl();
    return {i1.ex_pc_src, i1.ex_mem_to_reg, i1.ex_mem_read, i1.ex_mem_write,
            i1.ex_alu_op, i1.ex_alu_src, i1.ex_reg_write, i1.ex_reg_dst};
  endfunction

  // monitor: write enables checked mid-low-phase, EX state just after the edge
  exp_t m;
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (sb.size() > 0) begin
        m = sb[0];
        chk("pc_write_en", i1.pc_write_en, m.pcwe);
        chk("if_id_write_en", i1.if_id_write_en, m.pcwe);
        @(posedge clk);
        #1;
        chk("ex_valid", i1.ex_valid, m.vld);
        chk("ex_ctrl", act_ctrl(), m.ctrl);
        chk("ex_rs_data", i1.ex_rs_data, m.rsd);
        chk("ex_rt_data", i1.ex_rt_data, m.rtd);
        chk("ex_imm", i1.ex_imm, m.imm);
        chk("ex_pc_plus4", i1.ex_pc_plus4, m.pc4);
        chk("ex_rs", i1.ex_rs, m.rs);
        chk("ex_rt", i1.ex_rt, m.rt);
        chk("ex_rd", i1.ex_rd, m.rd);
        chk("bubble_count", i1.bubble_count, m.bub);
        chk("flush_count", i1.flush_count, m.flc);
        chk("flush_count_sat", i2.flush_count, m.sflc);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: run still active at %0t, required finish", $time);
    $fatal(1);
  end

  stim_t s1, s2, s3, s5, s6, s7, s8, s9, s10, s11, s12, s13, s15, sf;

  initial begin
    rst_n = 1'b0;
    apply(mk(1'b0, 10'h000, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0));
    #7;
    chk("rst_ex_valid", i1.ex_valid, 1'b0);
    chk("rst_ex_imm", i1.ex_imm, 32'h0);
    chk("rst_bubble_count", i1.bubble_count, 16'h0);
    chk("rst_flush_count", i1.flush_count, 16'h0);
    chk("rst_pc_write_en", i1.pc_write_en, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    i1.ext_stall = 1'b0;

    s1  = mk(1'b1, C_ADDI,  32'h11,  32'h22, 32'h5,  32'h104, 5'd1, 5'd8,  5'd0,  1'b0, 1'b0);
    s2  = mk(1'b1, C_LW,    32'h100, 32'h33, 32'h8,  32'h108, 5'd2, 5'd9,  5'd0,  1'b0, 1'b0);
    s3  = mk(1'b1, C_RTYPE, 32'h44,  32'h55, 32'h0,  32'h10C, 5'd9, 5'd3,  5'd10, 1'b0, 1'b0);
    s5  = mk(1'b1, C_LW,    32'h200, 32'h0,  32'h10, 32'h110, 5'd4, 5'd0,  5'd0,  1'b0, 1'b0);
    s6  = mk(1'b1, C_RTYPE, 32'h0,   32'h0,  32'h0,  32'h114, 5'd0, 5'd0,  5'd11, 1'b0, 1'b0);
    s7  = mk(1'b1, C_LW,    32'h300, 32'h66, 32'h4,  32'h118, 5'd2, 5'd9,  5'd0,  1'b0, 1'b0);
    s8  = mk(1'b1, C_ADDI,  32'h77,  32'h88, 32'h7,  32'h11C, 5'd5, 5'd9,  5'd0,  1'b0, 1'b0);
    s9  = mk(1'b1, C_LW,    32'h400, 32'h99, 32'hC,  32'h120, 5'd6, 5'd9,  5'd0,  1'b0, 1'b0);
    s10 = mk(1'b1, C_RTYPE, 32'h1,   32'h2,  32'h0,  32'h124, 5'd9, 5'd1,  5'd12, 1'b1, 1'b1);
    s11 = mk(1'b1, C_LW,    32'h500, 32'hAA, 32'h10, 32'h128, 5'd7, 5'd9,  5'd0,  1'b0, 1'b0);
    s12 = mk(1'b1, C_RTYPE, 32'h3,   32'h4,  32'h0,  32'h12C, 5'd9, 5'd1,  5'd12, 1'b1, 1'b0);
    s13 = mk(1'b1, C_RTYPE, 32'h3,   32'h4,  32'h0,  32'h12C, 5'd9, 5'd1,  5'd12, 1'b0, 1'b0);
    s15 = mk(1'b0, C_ADDI,  32'h5A,  32'hA5, 32'h3,  32'h130, 5'd1, 5'd2,  5'd3,  1'b0, 1'b0);
    sf  = mk(1'b0, 10'h000, 32'h0,   32'h0,  32'h0,  32'h0,   5'd0, 5'd0,  5'd0,  1'b0, 1'b1);

    step(s1,  ld(s1,  1'b1, 0, 0, 0));   // ADDI pass-through
    step(s2,  ld(s2,  1'b1, 0, 0, 0));   // LW $9
    step(s3,  bb(s2,  1'b0, 1, 0, 0));   // consumer of $9: one bubble, fetch held
    step(s3,  ld(s3,  1'b1, 1, 0, 0));   // consumer enters EX
    step(s5,  ld(s5,  1'b1, 1, 0, 0));   // LW into $0
    step(s6,  ld(s6,  1'b1, 1, 0, 0));   // reads $0: no stall
    step(s7,  ld(s7,  1'b1, 1, 0, 0));   // LW $9
    step(s8,  ld(s8,  1'b1, 1, 0, 0));   // ADDI writing $9: no stall
    step(s9,  ld(s9,  1'b1, 1, 0, 0));   // LW $9
    step(s10, zz(1'b0, 1, 1, 1));        // flush + load_use + ext_stall
    step(s11, ld(s11, 1'b1, 1, 1, 1));   // LW $9
    step(s12, ld(s11, 1'b0, 1, 1, 1));   // ext_stall with hazard: frozen
    step(s13, bb(s11, 1'b0, 2, 1, 1));   // stall dropped: bubble now
    step(s13, ld(s13, 1'b1, 2, 1, 1));
    step(s15, ld(s15, 1'b1, 2, 1, 1));   // id_valid=0: controls load as 0
    for (int k = 1; k <= 5; k++)
      step(sf, zz(1'b1, 2, 1 + k, (1 + k > 3) ? 3 : 1 + k));
    step(s1,  ld(s1,  1'b1, 2, 6, 3));

    // asynchronous reset in the middle of the high phase
    @(posedge clk);
    #3;
    i1.ext_stall = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ex_valid", i1.ex_valid, 1'b0);
    chk("async_rst_ex_ctrl", act_ctrl(), 10'h000);
    chk("async_rst_ex_imm", i1.ex_imm, 32'h0);
    chk("async_rst_ex_rt", i1.ex_rt, 5'd0);
    chk("async_rst_ex_pc_plus4", i1.ex_pc_plus4, 32'h0);
    chk("async_rst_bubble_count", i1.bubble_count, 16'h0);
    chk("async_rst_flush_count", i1.flush_count, 16'h0);
    chk("async_rst_flush_count_sat", i2.flush_count, 2'b00);
    chk("async_rst_pc_write_en", i1.pc_write_en, 1'b1);
    chk("async_rst_if_id_write_en", i1.if_id_write_en, 1'b1);

    for (int k = 0; k < 5 && sb.size() != 0; k++) @(posedge clk);
    if (sb.size() != 0) chk("scoreboard_drain", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
